// File: rtl/program_loader.sv
// Initiator side of the CPU program-edit interface: takes 32-bit instruction words
// from a valid/ready stream and writes each one as four MSB-first byte strobes into the ROM.
module program_loader #(
   parameter int ADDR_W       = 8,
   parameter int SETUP_CYCLES = 1,
   parameter int SEND_CYCLES  = 1,
   parameter int GAP_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              abort,
   input  logic              instr_valid,
   input  logic [31:0]       instr_data,
   input  logic              instr_last,
   output logic              instr_ready,
   output logic              edit,
   output logic [ADDR_W-1:0] unit,
   output logic [7:0]        code,
   output logic              send,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-2:0] word_count,
   output logic              err_overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_GAP,
      S_FIN
   } state_t;

   localparam logic [15:0]       SETUP_LAST = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0]       SEND_LAST  = 16'(SEND_CYCLES - 1);
   localparam logic [15:0]       GAP_LAST   = 16'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-2:0] COUNT_ONE  = (ADDR_W-1)'(1);

   state_t            state, state_nxt;
   logic [15:0]       cnt;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       word_q;
   logic              last_q;
   logic [1:0]        k;
   logic [ADDR_W-1:0] unit_q;
   logic [7:0]        code_q;

   logic              start_sess;
   logic              accept;
   logic              load_byte;
   logic [1:0]        byte_sel;
   logic              word_done;
   logic              set_err;
   logic [31:0]       byte_src;
   logic [7:0]        byte_val;

   // Sequencing: each phase dwells for its programmed cycle count, abort overrides everything
   always_comb begin
      state_nxt  = state;
      start_sess = 1'b0;
      accept     = 1'b0;
      load_byte  = 1'b0;
      byte_sel   = k;
      word_done  = 1'b0;
      set_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_sess = 1'b1;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (instr_valid) begin
               accept    = 1'b1;
               load_byte = 1'b1;
               byte_sel  = 2'd0;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt == SETUP_LAST) state_nxt = S_STROBE;
         end
         S_STROBE: begin
            if (cnt == SEND_LAST) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (k != 2'd3) begin
               load_byte = 1'b1;
               byte_sel  = k + 2'd1;
               state_nxt = S_SETUP;
            end else begin
               word_done = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               if (last_q) begin
                  state_nxt = S_FIN;
               end else if (ptr == '0) begin
                  set_err   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_FIN: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         state_nxt = S_IDLE;
         accept    = 1'b0;
         load_byte = 1'b0;
         word_done = 1'b0;
         set_err   = 1'b0;
      end
   end

   // The first byte of a word comes straight from the stream on the accepting edge
   always_comb begin
      byte_src = accept ? instr_data : word_q;
      byte_val = 8'h00;
      case (byte_sel)
         2'd0: byte_val = byte_src[31:24];
         2'd1: byte_val = byte_src[23:16];
         2'd2: byte_val = byte_src[15:8];
         2'd3: byte_val = byte_src[7:0];
         default: byte_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         ptr          <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         k            <= '0;
         unit_q       <= '0;
         code_q       <= '0;
         word_count   <= '0;
         err_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? '0 : cnt + 16'd1;
         if (start_sess) begin
            ptr          <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count   <= '0;
            err_overflow <= 1'b0;
         end
         if (accept) begin
            word_q <= instr_data;
            last_q <= instr_last;
         end
         // unit/code are registered so they hold through GAP and WAIT
         if (load_byte) begin
            k      <= byte_sel;
            unit_q <= ptr + {{(ADDR_W-2){1'b0}}, byte_sel};
            code_q <= byte_val;
         end
         if (word_done) begin
            ptr        <= ptr + WORD_STEP;
            word_count <= word_count + COUNT_ONE;
         end
         if (set_err) err_overflow <= 1'b1;
      end
   end

   assign instr_ready = (state == S_WAIT);
   assign edit        = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
   assign send        = (state == S_STROBE);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_FIN);
   assign unit        = unit_q;
   assign code        = code_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected ROM writes, done pulses and gap cycles
// are queued from a byte-level model and popped by a monitor watching the write strobe.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic        abort;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic        instr_last;
   logic        instr_ready;
   logic        edit;
   logic [7:0]  unit;
   logic [7:0]  code;
   logic        send;
   logic        busy;
   logic        done;
   logic [6:0]  word_count;
   logic        err_overflow;

   program_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .abort        (abort),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .instr_last   (instr_last),
      .instr_ready  (instr_ready),
      .edit         (edit),
      .unit         (unit),
      .code         (code),
      .send         (send),
      .busy         (busy),
      .done         (done),
      .word_count   (word_count),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [31:0] at;
   } wr_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] cyc = 0;
   wr_t         wr_q[$];
   logic [31:0] done_q[$];
   logic [31:0] gap_q[$];
   logic [31:0] sess_words[8];
   int          sess_gap[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_fail(input string name, input string what);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected none (cycle %0d)", name, what, cyc);
   endtask

   // Every strobe must match the oldest expected write, including the cycle it lands in
   always @(negedge clk) begin : monitor
      wr_t         e;
      logic [31:0] d;
      if (rst) begin
         if (send) begin
            if (wr_q.size() == 0) flag_fail("spurious_send", "send=1");
            else begin
               e = wr_q.pop_front();
               check_output("rom_write", {unit, code, cyc}, {e.addr, e.data, e.at});
            end
         end
         if (done) begin
            if (done_q.size() == 0) flag_fail("spurious_done", "done=1");
            else begin
               d = done_q.pop_front();
               check_output("done_cycle", cyc, d);
            end
         end
         if (gap_q.size() > 0 && gap_q[0] == cyc) begin
            void'(gap_q.pop_front());
            check_output("gap_edit", edit, 1'b0);
         end
      end
   end

   task automatic push_word(input logic [7:0] addr, input logic [31:0] d,
                            input logic [31:0] acc, input int nbytes);
      wr_t e;
      for (int i = 0; i < nbytes; i++) begin
         e.addr = addr + 8'(i);
         e.data = 8'(d >> (24 - 8 * i));
         e.at   = acc + 32'(1 + 3 * i);
         wr_q.push_back(e);
      end
   endtask

   task automatic apply_start(input logic [7:0] b);
      start     = 1'b1;
      base_addr = b;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = 8'($urandom);
   endtask

   task automatic apply_stimulus(input logic [31:0] d, input logic l,
                                 output logic [31:0] acc, output bit ok);
      instr_valid = 1'b1;
      instr_data  = d;
      instr_last  = l;
      ok  = 1'b0;
      acc = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (instr_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            ok  = 1'b1;
         end
      end
      instr_valid = 1'b0;
      instr_data  = $urandom;
      instr_last  = 1'($urandom);
      if (!ok) flag_fail("handshake", "timeout");
   endtask

   task automatic run_session(input logic [7:0] base, input int nw);
      logic [7:0]  ptr;
      logic [31:0] acc;
      logic [31:0] prev;
      bit          ok;
      bit          ovf;
      bit          saw;
      int          words;
      apply_start(base);
      ptr   = base & 8'hFC;
      ovf   = 1'b0;
      words = 0;
      prev  = '0;
      for (int n = 0; n < nw; n++) begin
         if (n > 0 && sess_gap[n] > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
               @(negedge clk);
               ok = instr_ready;
            end
            if (!ok) flag_fail("wait_ready", "timeout");
            for (int g = 0; g < sess_gap[n]; g++) begin
               @(posedge clk);
               #1;
               @(negedge clk);
               check_output("ready_while_idle", instr_ready, 1'b1);
            end
            @(posedge clk);
            #1;
         end
         apply_stimulus(sess_words[n], n == nw - 1, acc, ok);
         if (!ok) break;
         if (n > 0 && sess_gap[n] == 0) check_output("throughput", acc - prev, 32'd14);
         prev = acc;
         push_word(ptr, sess_words[n], acc, 4);
         gap_q.push_back(acc + 32'd12);
         words++;
         if (n == nw - 1) done_q.push_back(acc + 32'd13);
         else begin
            ptr = ptr + 8'd4;
            if (ptr == 8'h00) begin
               ovf = 1'b1;
               break;
            end
         end
      end
      if (ovf) begin
         instr_valid = 1'b1;
         instr_data  = sess_words[words];
         instr_last  = 1'b1;
         saw = 1'b0;
         repeat (30) begin
            @(negedge clk);
            if (instr_ready) saw = 1'b1;
         end
         check_output("ovf_no_accept", saw, 1'b0);
         instr_valid = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) flag_fail("session_end", "timeout");
      @(negedge clk);
      check_output("word_count", word_count, 7'(words));
      check_output("err_overflow", err_overflow, ovf);
      check_output("queues_drained", {wr_q.size(), done_q.size(), gap_q.size()}, '0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] acc;
      bit          ok;
      bit          saw;
      rst         = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      abort       = 1'b0;
      instr_valid = 1'b0;
      instr_data  = '0;
      instr_last  = 1'b0;
      #1;
      check_output("reset_outputs",
                   {instr_ready, edit, unit, code, send, busy, done, word_count, err_overflow}, '0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single word");
      sess_words[0] = 32'h30000008;
      sess_gap[0]   = 0;
      run_session(8'h00, 1);

      $display("[TB] three-word program");
      sess_words[0] = 32'h40000201;
      sess_words[1] = 32'h40000101;
      sess_words[2] = 32'h31000000;
      sess_gap[1]   = 0;
      sess_gap[2]   = 0;
      run_session(8'h04, 3);

      $display("[TB] backpressure and alignment");
      sess_words[0] = 32'hDEADBEEF;
      sess_words[1] = 32'h0BADF00D;
      sess_gap[1]   = 5;
      run_session(8'h05, 2);

      $display("[TB] overflow");
      sess_words[0] = 32'h12345678;
      sess_words[1] = 32'h9ABCDEF0;
      sess_gap[1]   = 0;
      run_session(8'hFC, 2);

      $display("[TB] abort during byte 2 strobe");
      apply_start(8'h20);
      apply_stimulus(32'hA1B2C3D4, 1'b1, acc, ok);
      if (ok) begin
         push_word(8'h20, 32'hA1B2C3D4, acc, 3);
         for (int i = 0; i < 30 && cyc != acc + 32'd7; i++) begin
            @(posedge clk);
            #1;
         end
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
         @(negedge clk);
         check_output("abort_outputs", {edit, send, busy, done, word_count}, '0);
         repeat (20) @(negedge clk);
         check_output("abort_drained", {wr_q.size(), done_q.size()}, '0);
         @(posedge clk);
         #1;
      end
      sess_words[0] = 32'h55AA33CC;
      run_session(8'h30, 1);

      $display("[TB] reset during byte 1 setup");
      apply_start(8'h40);
      apply_stimulus(32'h11223344, 1'b0, acc, ok);
      if (ok) begin
         push_word(8'h40, 32'h11223344, acc, 1);
         for (int i = 0; i < 30 && cyc != acc + 32'd3; i++) begin
            @(posedge clk);
            #1;
         end
         #2;
         rst = 1'b0;
         #1;
         check_output("async_reset_outputs",
                      {instr_ready, edit, unit, code, send, busy, done, word_count, err_overflow}, '0);
         @(posedge clk);
         #1;
         rst = 1'b1;
         instr_valid = 1'b1;
         instr_data  = 32'hCAFEF00D;
         saw = 1'b0;
         repeat (10) begin
            @(negedge clk);
            if (instr_ready || busy || send) saw = 1'b1;
         end
         instr_valid = 1'b0;
         check_output("idle_after_reset", saw, 1'b0);
         check_output("reset_drained", wr_q.size(), 0);
         @(posedge clk);
         #1;
      end

      $display("[TB] randomized sessions");
      for (int s = 0; s < 12; s++) begin
         int nw;
         nw = $urandom_range(1, 4);
         for (int n = 0; n < 8; n++) begin
            sess_words[n] = $urandom;
            sess_gap[n]   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
         end
         run_session(8'($urandom_range(0, 255)), nw);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
